// File: rtl/decode_unit_if.sv
// Fetch/write-back to decode-stage bundle: instruction, result buses, pipeline control
// and the registered decode outputs handed to execute.
interface decode_unit_if;
    logic        stall;
    logic        is_branch_taken;
    logic [15:0] instr;
    logic [19:0] rdvalmem1;
    logic [19:0] rdvalmem2;
    logic [4:0]  imm;
    logic [3:0]  opcode;
    logic [15:0] branch_target;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        imm_flag;

    modport master (
        output stall, is_branch_taken, instr, rdvalmem1, rdvalmem2,
        input  imm, opcode, branch_target, op1, op2, imm_flag
    );

    modport slave (
        input  stall, is_branch_taken, instr, rdvalmem1, rdvalmem2,
        output imm, opcode, branch_target, op1, op2, imm_flag
    );
endinterface

// File: rtl/decode_unit.sv
// Decode stage: field split, 8x16 register file with same-cycle forwarding from two
// result buses, and registered outputs with stall-hold and flush-to-NOP.
module decode_unit (
    input  logic          clk,
    input  logic          reset,
    decode_unit_if.slave  bus
);
    logic [15:0] regs [8];

    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        wr1_valid;
    logic        wr2_valid;
    logic [2:0]  wr1_idx;
    logic [2:0]  wr2_idx;
    logic [15:0] wr1_val;
    logic [15:0] wr2_val;
    logic [15:0] src1_val;
    logic [15:0] src2_val;
    logic [15:0] op2_next;
    logic [15:0] target_next;

    assign rs1       = bus.instr[7:5];
    assign rs2       = bus.instr[4:2];
    assign wr1_valid = bus.rdvalmem1[19];
    assign wr1_idx   = bus.rdvalmem1[18:16];
    assign wr1_val   = bus.rdvalmem1[15:0];
    assign wr2_valid = bus.rdvalmem2[19];
    assign wr2_idx   = bus.rdvalmem2[18:16];
    assign wr2_val   = bus.rdvalmem2[15:0];

    // Bus 1 is the younger result, so it overrides bus 2 and the stored value.
    always_comb begin
        src1_val = regs[rs1];
        if (wr2_valid && wr2_idx == rs1) src1_val = wr2_val;
        if (wr1_valid && wr1_idx == rs1) src1_val = wr1_val;

        src2_val = regs[rs2];
        if (wr2_valid && wr2_idx == rs2) src2_val = wr2_val;
        if (wr1_valid && wr1_idx == rs2) src2_val = wr1_val;

        op2_next    = bus.instr[11] ? {{11{bus.instr[4]}}, bus.instr[4:0]} : src2_val;
        target_next = {{5{bus.instr[10]}}, bus.instr[10:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            bus.imm           <= '0;
            bus.opcode        <= '0;
            bus.branch_target <= '0;
            bus.op1           <= '0;
            bus.op2           <= '0;
            bus.imm_flag      <= 1'b0;
        end else begin
            // Writes ignore stall/flush; bus 1 assigned last so it wins a collision.
            if (wr2_valid) regs[wr2_idx] <= wr2_val;
            if (wr1_valid) regs[wr1_idx] <= wr1_val;

            if (bus.is_branch_taken) begin
                bus.imm           <= '0;
                bus.opcode        <= '0;
                bus.branch_target <= '0;
                bus.op1           <= '0;
                bus.op2           <= '0;
                bus.imm_flag      <= 1'b0;
            end else if (!bus.stall) begin
                bus.imm           <= bus.instr[4:0];
                bus.opcode        <= bus.instr[15:12];
                bus.branch_target <= target_next;
                bus.op1           <= src1_val;
                bus.op2           <= op2_next;
                bus.imm_flag      <= bus.instr[11];
            end
        end
    end
endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: reset, register file, forwarding, immediates,
// flush, stall and mid-stream reset, each with hand-computed expectations.
module tb_decode_unit;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    decode_unit_if dif ();

    decode_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input logic [19:0] b1, input logic [19:0] b2,
                         input logic st, input logic fl);
        dif.instr           = i;
        dif.rdvalmem1       = b1;
        dif.rdvalmem2       = b2;
        dif.stall           = st;
        dif.is_branch_taken = fl;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(16'hFFFF, 20'hB1111, 20'hCEEEE, 1'b0, 1'b0);
        step();
        step();
        checks += 6;
        if (dif.imm !== 5'h0) begin failures++; $display("FAIL reset_imm got=%h exp=0", dif.imm); end
        if (dif.opcode !== 4'h0) begin failures++; $display("FAIL reset_opcode got=%h exp=0", dif.opcode); end
        if (dif.branch_target !== 16'h0) begin failures++; $display("FAIL reset_target got=%h exp=0", dif.branch_target); end
        if (dif.op1 !== 16'h0) begin failures++; $display("FAIL reset_op1 got=%h exp=0", dif.op1); end
        if (dif.op2 !== 16'h0) begin failures++; $display("FAIL reset_op2 got=%h exp=0", dif.op2); end
        if (dif.imm_flag !== 1'b0) begin failures++; $display("FAIL reset_imm_flag got=%b exp=0", dif.imm_flag); end
        reset = 1'b0;
        drive(16'h2170, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        checks += 3;
        if (dif.op1 !== 16'h0000) begin failures++; $display("FAIL post_reset_op1 got=%h exp=0000", dif.op1); end
        if (dif.op2 !== 16'h0000) begin failures++; $display("FAIL post_reset_op2 got=%h exp=0000", dif.op2); end
        if (dif.opcode !== 4'h2) begin failures++; $display("FAIL post_reset_opcode got=%h exp=2", dif.opcode); end
    endtask

    task automatic test_reg_write();
        drive(16'h0000, 20'hB1234, 20'h0, 1'b0, 1'b0);
        step();
        drive(16'h2170, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        checks += 5;
        if (dif.op1 !== 16'h1234) begin failures++; $display("FAIL regrd_op1 got=%h exp=1234", dif.op1); end
        if (dif.op2 !== 16'h0000) begin failures++; $display("FAIL regrd_op2 got=%h exp=0000", dif.op2); end
        if (dif.imm_flag !== 1'b0) begin failures++; $display("FAIL regrd_imm_flag got=%b exp=0", dif.imm_flag); end
        if (dif.imm !== 5'h10) begin failures++; $display("FAIL regrd_imm got=%h exp=10", dif.imm); end
        if (dif.branch_target !== 16'h0170) begin failures++; $display("FAIL regrd_target got=%h exp=0170", dif.branch_target); end
    endtask

    task automatic test_forwarding();
        drive(16'h2170, 20'h0, 20'hBABCD, 1'b0, 1'b0);
        step();
        checks++;
        if (dif.op1 !== 16'hABCD) begin failures++; $display("FAIL fwd_bus2_op1 got=%h exp=ABCD", dif.op1); end
        drive(16'h2170, 20'hB5555, 20'hBABCD, 1'b0, 1'b0);
        step();
        checks++;
        if (dif.op1 !== 16'h5555) begin failures++; $display("FAIL fwd_bus1_prio_op1 got=%h exp=5555", dif.op1); end
        // Collision wrote R3 from bus 1; rs2=4 forwarded from bus 2.
        drive(16'h2170, 20'h0, 20'hC0042, 1'b0, 1'b0);
        step();
        checks += 2;
        if (dif.op1 !== 16'h5555) begin failures++; $display("FAIL wr_collision_op1 got=%h exp=5555", dif.op1); end
        if (dif.op2 !== 16'h0042) begin failures++; $display("FAIL fwd_rs2_op2 got=%h exp=0042", dif.op2); end
        drive(16'h2170, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (dif.op2 !== 16'h0042) begin failures++; $display("FAIL bus2_write_op2 got=%h exp=0042", dif.op2); end
    endtask

    task automatic test_immediate();
        drive(16'h0000, 20'h90777, 20'h0, 1'b0, 1'b0);
        step();
        drive(16'h5A36, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        checks += 6;
        if (dif.opcode !== 4'h5) begin failures++; $display("FAIL imm_opcode got=%h exp=5", dif.opcode); end
        if (dif.imm_flag !== 1'b1) begin failures++; $display("FAIL imm_flag got=%b exp=1", dif.imm_flag); end
        if (dif.imm !== 5'b10110) begin failures++; $display("FAIL imm_field got=%b exp=10110", dif.imm); end
        if (dif.op2 !== 16'hFFF6) begin failures++; $display("FAIL imm_op2 got=%h exp=FFF6", dif.op2); end
        if (dif.branch_target !== 16'h0236) begin failures++; $display("FAIL imm_target got=%h exp=0236", dif.branch_target); end
        if (dif.op1 !== 16'h0777) begin failures++; $display("FAIL imm_op1 got=%h exp=0777", dif.op1); end
        drive(16'h0400, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (dif.branch_target !== 16'hFC00) begin failures++; $display("FAIL neg_target got=%h exp=FC00", dif.branch_target); end
    endtask

    task automatic test_flush();
        drive(16'h5A36, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        drive(16'hC567, 20'h0, 20'h0, 1'b1, 1'b1);
        step();
        checks += 6;
        if (dif.imm !== 5'h0) begin failures++; $display("FAIL flush_imm got=%h exp=0", dif.imm); end
        if (dif.opcode !== 4'h0) begin failures++; $display("FAIL flush_opcode got=%h exp=0", dif.opcode); end
        if (dif.branch_target !== 16'h0) begin failures++; $display("FAIL flush_target got=%h exp=0", dif.branch_target); end
        if (dif.op1 !== 16'h0) begin failures++; $display("FAIL flush_op1 got=%h exp=0", dif.op1); end
        if (dif.op2 !== 16'h0) begin failures++; $display("FAIL flush_op2 got=%h exp=0", dif.op2); end
        if (dif.imm_flag !== 1'b0) begin failures++; $display("FAIL flush_imm_flag got=%b exp=0", dif.imm_flag); end
    endtask

    task automatic test_stall();
        drive(16'h5A36, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        drive(16'hD789, 20'h8ABCD, 20'h0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            checks += 6;
            if (dif.opcode !== 4'h5) begin failures++; $display("FAIL stall%0d_opcode got=%h exp=5", k, dif.opcode); end
            if (dif.imm_flag !== 1'b1) begin failures++; $display("FAIL stall%0d_imm_flag got=%b exp=1", k, dif.imm_flag); end
            if (dif.imm !== 5'h16) begin failures++; $display("FAIL stall%0d_imm got=%h exp=16", k, dif.imm); end
            if (dif.op1 !== 16'h0777) begin failures++; $display("FAIL stall%0d_op1 got=%h exp=0777", k, dif.op1); end
            if (dif.op2 !== 16'hFFF6) begin failures++; $display("FAIL stall%0d_op2 got=%h exp=FFF6", k, dif.op2); end
            if (dif.branch_target !== 16'h0236) begin failures++; $display("FAIL stall%0d_target got=%h exp=0236", k, dif.branch_target); end
            dif.rdvalmem1 = 20'h0;
        end
        drive(16'h2000, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        checks += 3;
        if (dif.opcode !== 4'h2) begin failures++; $display("FAIL unstall_opcode got=%h exp=2", dif.opcode); end
        if (dif.op1 !== 16'hABCD) begin failures++; $display("FAIL stall_write_op1 got=%h exp=ABCD", dif.op1); end
        if (dif.op2 !== 16'hABCD) begin failures++; $display("FAIL stall_write_op2 got=%h exp=ABCD", dif.op2); end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        drive(16'h2170, 20'hB7777, 20'h0, 1'b0, 1'b0);
        step();
        checks += 2;
        if (dif.op1 !== 16'h0) begin failures++; $display("FAIL midrst_op1 got=%h exp=0", dif.op1); end
        if (dif.opcode !== 4'h0) begin failures++; $display("FAIL midrst_opcode got=%h exp=0", dif.opcode); end
        reset = 1'b0;
        drive(16'h2170, 20'h0, 20'h0, 1'b0, 1'b0);
        step();
        checks += 3;
        if (dif.opcode !== 4'h2) begin failures++; $display("FAIL midrst_next_opcode got=%h exp=2", dif.opcode); end
        if (dif.op1 !== 16'h0) begin failures++; $display("FAIL midrst_r3_cleared got=%h exp=0", dif.op1); end
        if (dif.op2 !== 16'h0) begin failures++; $display("FAIL midrst_r4_cleared got=%h exp=0", dif.op2); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(16'h0, 20'h0, 20'h0, 1'b0, 1'b0);
        test_reset();
        test_reg_write();
        test_forwarding();
        test_immediate();
        test_flush();
        test_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_unit.md
# decode_unit

Instruction-decode stage of the 16-bit pipelined processor: sits between fetch and execute. Each cycle it splits the incoming instruction into fields, reads source operands from an internal 8×16 register file and forwards results arriving on the two memory/write-back buses. It registers the decoded fields and operands for the execute stage, and supports stall (hold) and branch-flush (bubble).

## Interface
- Parameters: none.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hold all decode outputs.
- `is_branch_taken` input 1: flush; the next output is a bubble.
- `instr` input 16: instruction from fetch.
- `rdvalmem1` input 20: result bus 1. Fields are [19] valid, [18:16] destination register, [15:0] value.
- `rdvalmem2` input 20: result bus 2, same format.
- `imm` output 5: registered `instr[4:0]`.
- `opcode` output 4: registered `instr[15:12]`.
- `branch_target` output 16: registered sign-extended `instr[10:0]`.
- `op1` output 16: registered source operand 1.
- `op2` output 16: registered source operand 2, or the sign-extended immediate.
- `imm_flag` output 1: registered `instr[11]`.

## Operation
- Instruction fields:
  - opcode = [15:12]
  - imm_flag = [11]
  - rd = [10:8]
  - rs1 = [7:5]
  - rs2 = [4:2]
  - imm = [4:0]
- Register file: 8 entries × 16 bits, all writable; R0 is not hardwired. Write rules:
  - Each rising edge, if `rdvalmem1[19]` = 1, write `rdvalmem1[15:0]` to R[`rdvalmem1[18:16]`]. Apply the same rule for bus 2.
  - If both buses are valid with the same index, bus 1 wins.
  - Writes occur regardless of `stall` or `is_branch_taken`.
- Operand source selection, combinational, per source `rsX`, in priority order:
  1. Bus 1 valid and index == rsX → `rdvalmem1[15:0]`.
  2. Otherwise bus 2 valid and index == rsX → `rdvalmem2[15:0]`.
  3. Otherwise R[rsX], the value before this edge's write.
- `op1` = selected(rs1).
- `op2` = imm_flag ? {{11{instr[4]}}, instr[4:0]} : selected(rs2).
- `branch_target` = {{5{instr[10]}}, instr[10:0]}. It is always computed; execute decides whether to use it.
- Output register update, each rising edge, in priority order:
  1. `reset`: all outputs cleared to 0 and all 8 registers cleared to 0.
  2. `is_branch_taken`: all outputs cleared to 0. This is a NOP bubble, since opcode 0000 = NOP. It has priority over `stall`.
  3. `stall`: all outputs hold their values. `instr` is ignored.
  4. Otherwise: outputs load the decoded values above.

## Timing
- Latency: 1 cycle; instruction presented before edge N appears on outputs after edge N.
- Reset value of every output is 0; register file is all-zero after reset.
- Forwarding is same-cycle. A value on a result bus at edge N is visible to the instruction decoded at edge N, and to all later instructions through the register file.
- Simultaneous flush and stall: flush wins.
- Simultaneous reset and a valid bus write: reset wins; the register stays 0.
- A stall lasting several cycles holds the outputs for every stalled cycle. Register writes continue during the stall, so operands are re-read when the stall is released.
- Reset asserted mid-stream clears everything on that edge. The first instruction after deassertion decodes normally one cycle later.

## Test plan
- **Reset:** `reset`=1 for 2 edges, other inputs arbitrary. Required response: all outputs 0. Then decode `instr`=0x2170 (rs1=3, rs2=4) with no bus writes: op1=0x0000, op2=0x0000, opcode=0x2.
- **Register write then read:** one edge with `rdvalmem1`=0xB1234 (writes R3=0x1234). Then `instr`=0x2170 with buses 0. Required response: op1=0x1234, op2=0x0000, imm_flag=0.
- **Forwarding:** R3=0x1234 in the register file, `instr`=0x2170, `rdvalmem2`=0xBABCD. Required response: op1=0xABCD. With `rdvalmem1`=0xB5555 also asserted in the same cycle, op1=0x5555 (bus 1 priority).
- **Immediate:** `instr`=0x5A36. Required response: opcode=0x5, imm_flag=1, imm=10110, op2=0xFFF6, branch_target=0x0236, op1=R1.
- **Flush:** valid outputs present, then `is_branch_taken`=1 with `stall`=1 and `instr`=0xC567. Required response: all outputs 0 after the edge.
- **Stall:** outputs hold across 2 stalled edges while `instr`=0xD789. A `rdvalmem1`=0x8ABCD presented during the stall still writes R0=0xABCD.
